// File: rtl/decode_pkg.sv
// Shared decode encodings and the control bundle handed from ID to EX.
// Optional M-extension fields are compiled in with DECODE_MEXT_EN.
package decode_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned REG_W  = 5;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    localparam logic [1:0] WB_NONE = 2'b00;
    localparam logic [1:0] WB_JUMP = 2'b01;
    localparam logic [1:0] WB_ALU  = 2'b10;
    localparam logic [1:0] WB_LOAD = 2'b11;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_EQ   = 3'b010;
    localparam logic [2:0] BR_NE   = 3'b011;
    localparam logic [2:0] BR_LT   = 3'b100;
    localparam logic [2:0] BR_GE   = 3'b101;
    localparam logic [2:0] BR_LTU  = 3'b110;
    localparam logic [2:0] BR_GEU  = 3'b111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_LUI  = 4'b1110;

    localparam logic [2:0] DMR_NONE = 3'b000;
    localparam logic [2:0] DMR_LB   = 3'b001;
    localparam logic [2:0] DMR_LBU  = 3'b010;
    localparam logic [2:0] DMR_LH   = 3'b011;
    localparam logic [2:0] DMR_LHU  = 3'b100;
    localparam logic [2:0] DMR_LW   = 3'b101;
    localparam logic [2:0] DMR_LD   = 3'b110;
    localparam logic [2:0] DMR_LWU  = 3'b111;

    localparam logic [2:0] DMW_NONE = 3'b000;
    localparam logic [2:0] DMW_SB   = 3'b001;
    localparam logic [2:0] DMW_SH   = 3'b010;
    localparam logic [2:0] DMW_SW   = 3'b011;
    localparam logic [2:0] DMW_SD   = 3'b100;

    typedef struct packed {
        logic       rf_wr_en;
        logic [1:0] rf_wr_sel;
        logic       do_jump;
        logic       is_branch;
        logic [2:0] br_type;
        logic       alu_a_sel;   // 1: PC, 0: rs1
        logic       alu_b_sel;   // 1: immediate, 0: rs2
        logic [3:0] alu_ctrl;
        logic [2:0] dm_rd_ctrl;
        logic [2:0] dm_wr_ctrl;
        logic       is_debug;
        logic       is_syscall;
        logic       rs1_used;
        logic       rs2_used;
        logic       is_word;
`ifdef DECODE_MEXT_EN
        logic       mdu_en;
        logic [2:0] mdu_op;
`endif
    } ctrl_t;

endpackage

// File: rtl/decode_if.sv
// IF->ID->EX handshake bundle; slave is the decode stage, master the neighbours.
interface decode_if #(parameter int unsigned PC_W = 64);
    import decode_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [PC_W-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    ctrl_t           out_ctrl;
    logic [PC_W-1:0] out_pc;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_inst, in_pc, flush, out_ready,
        output in_ready, out_valid, out_ctrl, out_pc, out_rd, out_rs1, out_rs2, out_illegal
    );

    modport master (
        output in_valid, in_inst, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_ctrl, out_pc, out_rd, out_rs1, out_rs2, out_illegal
    );
endinterface

// File: rtl/decode_comb.sv
// Pure combinational RV32I/RV64I instruction decoder (M extension with DECODE_MEXT_EN).
module decode_comb
    import decode_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [31:0] i_inst,
    output ctrl_t       o_ctrl_c,
    output logic        o_illegal_c,
    output logic [4:0]  o_rd_c,
    output logic [4:0]  o_rs1_c,
    output logic [4:0]  o_rs2_c
);
    localparam bit RV64 = (XLEN == 64);

    logic [6:0] w_opc;
    logic [6:0] w_f7;
    logic [2:0] w_f3;
    logic       w_sh_log;
    logic       w_sh_ari;
    logic       w_legal;
    ctrl_t      w_c;

    assign w_opc = i_inst[6:0];
    assign w_f3  = i_inst[14:12];
    assign w_f7  = i_inst[31:25];
    // Shift-immediate qualifiers: bit 25 is shamt[5] at RV64 but must be clear at RV32
    assign w_sh_log = (i_inst[31:26] == 6'b000000) && (RV64 || !i_inst[25]);
    assign w_sh_ari = (i_inst[31:26] == 6'b010000) && (RV64 || !i_inst[25]);

    // Opcode/funct decode; anything not explicitly legal collapses to an all-zero bundle
    always_comb begin
        w_c     = '0;
        w_legal = 1'b0;
        case (w_opc)
            OPC_LUI: begin
                w_legal = 1'b1; w_c.rf_wr_en = 1'b1; w_c.rf_wr_sel = WB_ALU;
                w_c.alu_b_sel = 1'b1; w_c.alu_ctrl = ALU_LUI;
            end
            OPC_AUIPC: begin
                w_legal = 1'b1; w_c.rf_wr_en = 1'b1; w_c.rf_wr_sel = WB_ALU;
                w_c.alu_a_sel = 1'b1; w_c.alu_b_sel = 1'b1;
            end
            OPC_JAL: begin
                w_legal = 1'b1; w_c.rf_wr_en = 1'b1; w_c.rf_wr_sel = WB_JUMP;
                w_c.do_jump = 1'b1; w_c.alu_a_sel = 1'b1; w_c.alu_b_sel = 1'b1;
            end
            OPC_JALR: begin
                w_legal = (w_f3 == 3'b000); w_c.rf_wr_en = 1'b1; w_c.rf_wr_sel = WB_JUMP;
                w_c.do_jump = 1'b1; w_c.alu_b_sel = 1'b1; w_c.rs1_used = 1'b1;
            end
            OPC_BRANCH: begin
                w_c.is_branch = 1'b1; w_c.rs1_used = 1'b1; w_c.rs2_used = 1'b1;
                w_legal = 1'b1;
                case (w_f3)
                    3'b000:  w_c.br_type = BR_EQ;
                    3'b001:  w_c.br_type = BR_NE;
                    3'b100:  w_c.br_type = BR_LT;
                    3'b101:  w_c.br_type = BR_GE;
                    3'b110:  w_c.br_type = BR_LTU;
                    3'b111:  w_c.br_type = BR_GEU;
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                w_c.rf_wr_en = 1'b1; w_c.rf_wr_sel = WB_LOAD;
                w_c.alu_b_sel = 1'b1; w_c.rs1_used = 1'b1;
                w_legal = 1'b1;
                case (w_f3)
                    3'b000:  w_c.dm_rd_ctrl = DMR_LB;
                    3'b001:  w_c.dm_rd_ctrl = DMR_LH;
                    3'b010:  w_c.dm_rd_ctrl = DMR_LW;
                    3'b100:  w_c.dm_rd_ctrl = DMR_LBU;
                    3'b101:  w_c.dm_rd_ctrl = DMR_LHU;
                    3'b011:  begin w_c.dm_rd_ctrl = DMR_LD;  w_legal = RV64; end
                    3'b110:  begin w_c.dm_rd_ctrl = DMR_LWU; w_legal = RV64; end
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_STORE: begin
                w_c.alu_b_sel = 1'b1; w_c.rs1_used = 1'b1; w_c.rs2_used = 1'b1;
                w_legal = 1'b1;
                case (w_f3)
                    3'b000:  w_c.dm_wr_ctrl = DMW_SB;
                    3'b001:  w_c.dm_wr_ctrl = DMW_SH;
                    3'b010:  w_c.dm_wr_ctrl = DMW_SW;
                    3'b011:  begin w_c.dm_wr_ctrl = DMW_SD; w_legal = RV64; end
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                w_c.rf_wr_en = 1'b1; w_c.rf_wr_sel = WB_ALU;
                w_c.alu_b_sel = 1'b1; w_c.rs1_used = 1'b1;
                w_legal = 1'b1;
                case (w_f3)
                    3'b000:  w_c.alu_ctrl = ALU_ADD;
                    3'b010:  w_c.alu_ctrl = ALU_SLT;
                    3'b011:  w_c.alu_ctrl = ALU_SLTU;
                    3'b100:  w_c.alu_ctrl = ALU_XOR;
                    3'b110:  w_c.alu_ctrl = ALU_OR;
                    3'b111:  w_c.alu_ctrl = ALU_AND;
                    3'b001:  begin w_c.alu_ctrl = ALU_SLL; w_legal = w_sh_log; end
                    default: begin
                        w_c.alu_ctrl = w_sh_ari ? ALU_SRA : ALU_SRL;
                        w_legal      = w_sh_log | w_sh_ari;
                    end
                endcase
            end
            OPC_OP, OPC_OP_32: begin
                w_c.rf_wr_en = 1'b1; w_c.rf_wr_sel = WB_ALU;
                w_c.rs1_used = 1'b1; w_c.rs2_used = 1'b1;
                w_c.is_word  = (w_opc == OPC_OP_32);
                if (w_f7 == 7'b0000000) begin
                    case (w_f3)
                        3'b000:  begin w_c.alu_ctrl = ALU_ADD;  w_legal = 1'b1; end
                        3'b001:  begin w_c.alu_ctrl = ALU_SLL;  w_legal = 1'b1; end
                        3'b101:  begin w_c.alu_ctrl = ALU_SRL;  w_legal = 1'b1; end
                        3'b010:  begin w_c.alu_ctrl = ALU_SLT;  w_legal = !w_c.is_word; end
                        3'b011:  begin w_c.alu_ctrl = ALU_SLTU; w_legal = !w_c.is_word; end
                        3'b100:  begin w_c.alu_ctrl = ALU_XOR;  w_legal = !w_c.is_word; end
                        3'b110:  begin w_c.alu_ctrl = ALU_OR;   w_legal = !w_c.is_word; end
                        default: begin w_c.alu_ctrl = ALU_AND;  w_legal = !w_c.is_word; end
                    endcase
                end else if (w_f7 == 7'b0100000) begin
                    if (w_f3 == 3'b000) begin
                        w_c.alu_ctrl = ALU_SUB; w_legal = 1'b1;
                    end else if (w_f3 == 3'b101) begin
                        w_c.alu_ctrl = ALU_SRA; w_legal = 1'b1;
                    end
`ifdef DECODE_MEXT_EN
                end else if (w_f7 == 7'b0000001) begin
                    w_c.mdu_en = 1'b1; w_c.mdu_op = w_f3;
                    // mulhsu/mulh/mulhu have no word form
                    w_legal = !w_c.is_word || (w_f3 == 3'b000) || w_f3[2];
`endif
                end
                if (w_c.is_word && !RV64) w_legal = 1'b0;
            end
            OPC_OP_IMM_32: begin
                w_c.rf_wr_en = 1'b1; w_c.rf_wr_sel = WB_ALU; w_c.is_word = 1'b1;
                w_c.alu_b_sel = 1'b1; w_c.rs1_used = 1'b1;
                case (w_f3)
                    3'b000:  begin w_c.alu_ctrl = ALU_ADD; w_legal = 1'b1; end
                    3'b001:  begin w_c.alu_ctrl = ALU_SLL; w_legal = (w_f7 == 7'b0000000); end
                    3'b101:  begin
                        w_c.alu_ctrl = w_f7[5] ? ALU_SRA : ALU_SRL;
                        w_legal      = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
                    end
                    default: w_legal = 1'b0;
                endcase
                if (!RV64) w_legal = 1'b0;
            end
            OPC_SYSTEM: begin
                if (i_inst == 32'h0000_0073) begin
                    w_legal = 1'b1; w_c.is_syscall = 1'b1;
                end else if (i_inst == 32'h0010_0073) begin
                    w_legal = 1'b1; w_c.is_debug = 1'b1;
                end
            end
            default: w_legal = 1'b0;
        endcase
        if (!w_legal) w_c = '0;
    end

    assign o_ctrl_c    = w_c;
    assign o_illegal_c = !w_legal;
    assign o_rd_c      = w_c.rf_wr_en ? i_inst[11:7]  : 5'd0;
    assign o_rs1_c     = w_c.rs1_used ? i_inst[19:15] : 5'd0;
    assign o_rs2_c     = w_c.rs2_used ? i_inst[24:20] : 5'd0;
endmodule

// File: rtl/decode_stage.sv
// ID stage: decoder feeding a 2-entry skid buffer so EX back-pressure never
// reaches IF combinationally. Optional M extension: DECODE_MEXT_EN.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned XLEN = 64,
    parameter int unsigned PC_W = XLEN
) (
    input  logic     clk,
    input  logic     rst_n,
    decode_if.slave  bus
);
    typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} state_t;

    typedef struct packed {
        ctrl_t           ctrl;
        logic [PC_W-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            illegal;
    } entry_t;

    state_t r_state, w_state_nxt;
    logic   r_out_valid, r_in_ready;
    entry_t r_main, r_skid, w_new;
    logic   w_accept, w_emit;
    logic   w_ld_main_new, w_ld_main_skid, w_ld_skid;

    decode_comb #(.XLEN(XLEN)) u_dec (
        .i_inst      (bus.in_inst),
        .o_ctrl_c    (w_new.ctrl),
        .o_illegal_c (w_new.illegal),
        .o_rd_c      (w_new.rd),
        .o_rs1_c     (w_new.rs1),
        .o_rs2_c     (w_new.rs2)
    );
    assign w_new.pc = bus.in_pc;

    assign w_accept = bus.in_valid & r_in_ready;
    assign w_emit   = r_out_valid & bus.out_ready;

    // Next state and entry-load strobes; flush overrides every other event
    always_comb begin
        w_state_nxt    = r_state;
        w_ld_main_new  = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        if (bus.flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_accept) begin
                    w_state_nxt = S_ONE; w_ld_main_new = 1'b1;
                end
                S_ONE: begin
                    if (w_accept && !w_emit) begin
                        w_state_nxt = S_TWO; w_ld_skid = 1'b1;
                    end else if (w_emit && !w_accept) begin
                        w_state_nxt = S_EMPTY;
                    end else if (w_emit && w_accept) begin
                        w_ld_main_new = 1'b1;
                    end
                end
                S_TWO: if (w_emit) begin
                    w_state_nxt = S_ONE; w_ld_main_skid = 1'b1;
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    // State register with registered handshake flags derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt != S_EMPTY);
            r_in_ready  <= (w_state_nxt != S_TWO);
        end
    end

    // Entry storage: main drives EX, skid catches one beat of back-pressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_ld_main_new) begin
                r_main <= w_new;
            end else if (w_ld_main_skid) begin
                r_main <= r_skid;
            end
            if (w_ld_skid) begin
                r_skid <= w_new;
            end
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_ctrl    = r_main.ctrl;
    assign bus.out_pc      = r_main.pc;
    assign bus.out_rd      = r_main.rd;
    assign bus.out_rs1     = r_main.rs1;
    assign bus.out_rs2     = r_main.rs2;
    assign bus.out_illegal = r_main.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage (XLEN=64 and XLEN=32 instances) with an in-order scoreboard.
module tb_decode_stage;
    import decode_pkg::*;

    typedef struct packed {
        logic [63:0] pc;
        ctrl_t       ctrl;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        ill;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    decode_if #(.PC_W(64)) bus64 ();
    decode_if #(.PC_W(32)) bus32 ();

    decode_stage #(.XLEN(64), .PC_W(64)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));
    decode_stage #(.XLEN(32), .PC_W(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic ctrl_t mk(input logic wr, input logic [1:0] sel, input logic jmp,
                                 input logic br, input logic [2:0] brt, input logic as,
                                 input logic bs, input logic [3:0] alu, input logic [2:0] dmr,
                                 input logic [2:0] dmw, input logic r1, input logic r2,
                                 input logic w);
        ctrl_t c;
        c = '0;
        c.rf_wr_en = wr; c.rf_wr_sel = sel; c.do_jump = jmp; c.is_branch = br;
        c.br_type = brt; c.alu_a_sel = as; c.alu_b_sel = bs; c.alu_ctrl = alu;
        c.dm_rd_ctrl = dmr; c.dm_wr_ctrl = dmw; c.rs1_used = r1; c.rs2_used = r2;
        c.is_word = w;
        return c;
    endfunction

    function automatic exp_t ex(input logic [63:0] pc, input ctrl_t c, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic ill);
        exp_t e;
        e.pc = pc; e.ctrl = c; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.ill = ill;
        return e;
    endfunction

    // One cycle on the 64-bit DUT: drive at negedge, score emit/accept, advance to next negedge
    task automatic step(input logic v, input logic [31:0] inst, input exp_t e,
                        input logic ordy, input logic fl);
        exp_t w;
        bus64.in_valid  = v;
        bus64.in_inst   = inst;
        bus64.in_pc     = e.pc;
        bus64.out_ready = ordy;
        bus64.flush     = fl;
        #1;
        if (bus64.out_valid && ordy && !fl) begin
            checks++;
            assert (q.size() > 0) else begin
                errors++;
                $error("FAIL spurious_out: observed pc=%0h expected no output", bus64.out_pc);
            end
            if (q.size() > 0) begin
                w = q.pop_front();
                chk("sb_pc",   bus64.out_pc, w.pc);
                chk("sb_ctrl", 64'(bus64.out_ctrl), 64'(w.ctrl));
                chk("sb_rd",   64'(bus64.out_rd), 64'(w.rd));
                chk("sb_rs1",  64'(bus64.out_rs1), 64'(w.rs1));
                chk("sb_rs2",  64'(bus64.out_rs2), 64'(w.rs2));
                chk("sb_ill",  64'(bus64.out_illegal), 64'(w.ill));
            end
        end
        if (fl) q.delete();
        else if (v && bus64.in_ready) q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        exp_t z;
        z = '0;
        for (int i = 0; i < budget && (q.size() > 0 || bus64.out_valid); i++)
            step(1'b0, 32'h0, z, 1'b1, 1'b0);
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    // Single accepted instruction on the 32-bit DUT, leaving outputs for inspection
    task automatic step32(input logic [31:0] inst);
        bus32.in_valid  = 1'b1;
        bus32.in_inst   = inst;
        bus32.in_pc     = 32'h40;
        bus32.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus32.in_valid = 1'b0;
        #1;
    endtask

    localparam logic [31:0] I_ADDI  = 32'h0050_0093;
    localparam logic [31:0] I_BEQ   = 32'h0020_8463;
    localparam logic [31:0] I_SD    = 32'h0020_B823;
    localparam logic [31:0] I_LD    = 32'h0000_3083;
    localparam logic [31:0] I_MUL   = 32'h0220_8033;
    localparam logic [31:0] I_ADD   = 32'h0020_81B3;
    localparam logic [31:0] I_SUB   = 32'h4020_81B3;
    localparam logic [31:0] I_ADDW  = 32'h0020_81BB;
    localparam logic [31:0] I_SRAI  = 32'h4210_D093;
    localparam logic [31:0] I_JAL   = 32'h0100_00EF;
    localparam logic [31:0] I_JALR  = 32'h0000_8067;
    localparam logic [31:0] I_LUI   = 32'h1234_52B7;
    localparam logic [31:0] I_ECALL = 32'h0000_0073;
    localparam logic [31:0] I_EBRK  = 32'h0010_0073;
    localparam logic [31:0] I_BAD   = 32'hFFFF_FFFF;

    initial begin
        ctrl_t c_addi, c_beq, c_sd, c_ld, c_add, c_sub, c_addw, c_srai, c_jal, c_jalr, c_lui;
        ctrl_t c_ecall, c_ebrk, c_mul;
        exp_t  z;
        logic  mul_ill;

        z      = '0;
        c_addi = mk(1, 2'b10, 0, 0, 3'b000, 0, 1, 4'b0000, 3'b000, 3'b000, 1, 0, 0);
        c_beq  = mk(0, 2'b00, 0, 1, 3'b010, 0, 0, 4'b0000, 3'b000, 3'b000, 1, 1, 0);
        c_sd   = mk(0, 2'b00, 0, 0, 3'b000, 0, 1, 4'b0000, 3'b000, 3'b100, 1, 1, 0);
        c_ld   = mk(1, 2'b11, 0, 0, 3'b000, 0, 1, 4'b0000, 3'b110, 3'b000, 1, 0, 0);
        c_add  = mk(1, 2'b10, 0, 0, 3'b000, 0, 0, 4'b0000, 3'b000, 3'b000, 1, 1, 0);
        c_sub  = mk(1, 2'b10, 0, 0, 3'b000, 0, 0, 4'b1000, 3'b000, 3'b000, 1, 1, 0);
        c_addw = mk(1, 2'b10, 0, 0, 3'b000, 0, 0, 4'b0000, 3'b000, 3'b000, 1, 1, 1);
        c_srai = mk(1, 2'b10, 0, 0, 3'b000, 0, 1, 4'b1101, 3'b000, 3'b000, 1, 0, 0);
        c_jal  = mk(1, 2'b01, 1, 0, 3'b000, 1, 1, 4'b0000, 3'b000, 3'b000, 0, 0, 0);
        c_jalr = mk(1, 2'b01, 1, 0, 3'b000, 0, 1, 4'b0000, 3'b000, 3'b000, 1, 0, 0);
        c_lui  = mk(1, 2'b10, 0, 0, 3'b000, 0, 1, 4'b1110, 3'b000, 3'b000, 0, 0, 0);
        c_ecall = '0; c_ecall.is_syscall = 1'b1;
        c_ebrk  = '0; c_ebrk.is_debug    = 1'b1;
`ifdef DECODE_MEXT_EN
        c_mul   = mk(1, 2'b10, 0, 0, 3'b000, 0, 0, 4'b0000, 3'b000, 3'b000, 1, 1, 0);
        c_mul.mdu_en = 1'b1; c_mul.mdu_op = 3'b000;
        mul_ill = 1'b0;
`else
        c_mul   = '0;
        mul_ill = 1'b1;
`endif

        // Reset held with IF already presenting an instruction
        rst_n = 1'b0;
        bus64.in_valid = 1'b1; bus64.in_inst = I_ADDI; bus64.in_pc = 64'h100;
        bus64.out_ready = 1'b1; bus64.flush = 1'b0;
        bus32.in_valid = 1'b0; bus32.in_inst = 32'h0; bus32.in_pc = 32'h0;
        bus32.out_ready = 1'b1; bus32.flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready",  64'(bus64.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus64.out_valid), 64'd0);
        chk("rst_out_ctrl",  64'(bus64.out_ctrl), 64'd0);
        chk("rst_out_pc",    bus64.out_pc, 64'd0);
        chk("rst_out_rd",    64'(bus64.out_rd), 64'd0);
        chk("rst_out_ill",   64'(bus64.out_illegal), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First transaction: one-cycle latency
        step(1, I_ADDI, ex(64'h100, c_addi, 5'd1, 5'd0, 5'd0, 1'b0), 1, 0);
        chk("lat_out_valid", 64'(bus64.out_valid), 64'd1);
        chk("lat_out_rd",    64'(bus64.out_rd), 64'd1);
        drain(4);

        // Back-pressure: two stalled cycles fill main and skid
        step(1, I_ADDI, ex(64'h200, c_addi, 5'd1, 5'd0, 5'd0, 1'b0), 1, 0);
        step(1, I_BEQ,  ex(64'h204, c_beq,  5'd0, 5'd1, 5'd2, 1'b0), 0, 0);
        chk("two_in_ready", 64'(bus64.in_ready), 64'd0);
        step(1, I_SD,   ex(64'h208, c_sd,   5'd0, 5'd1, 5'd2, 1'b0), 0, 0);
        chk("stall_pc",   bus64.out_pc, 64'h200);
        chk("stall_ctrl", 64'(bus64.out_ctrl), 64'(c_addi));
        chk("stall_in_ready", 64'(bus64.in_ready), 64'd0);
        step(1, I_SD,   ex(64'h208, c_sd,   5'd0, 5'd1, 5'd2, 1'b0), 1, 0);
        step(1, I_SD,   ex(64'h208, c_sd,   5'd0, 5'd1, 5'd2, 1'b0), 1, 0);
        drain(6);

        // Streaming mix at full throughput, including illegal and RV64-only encodings
        step(1, I_JAL,   ex(64'h300, c_jal,   5'd1, 5'd0, 5'd0, 1'b0), 1, 0);
        step(1, I_JALR,  ex(64'h304, c_jalr,  5'd0, 5'd1, 5'd0, 1'b0), 1, 0);
        step(1, I_LUI,   ex(64'h308, c_lui,   5'd5, 5'd0, 5'd0, 1'b0), 1, 0);
        step(1, I_ADD,   ex(64'h30C, c_add,   5'd3, 5'd1, 5'd2, 1'b0), 1, 0);
        step(1, I_SUB,   ex(64'h310, c_sub,   5'd3, 5'd1, 5'd2, 1'b0), 1, 0);
        step(1, I_SRAI,  ex(64'h314, c_srai,  5'd1, 5'd1, 5'd0, 1'b0), 1, 0);
        step(1, I_ADDW,  ex(64'h318, c_addw,  5'd3, 5'd1, 5'd2, 1'b0), 1, 0);
        step(1, I_ECALL, ex(64'h31C, c_ecall, 5'd0, 5'd0, 5'd0, 1'b0), 1, 0);
        step(1, I_EBRK,  ex(64'h320, c_ebrk,  5'd0, 5'd0, 5'd0, 1'b0), 1, 0);
        step(1, I_BAD,   ex(64'h324, '0,      5'd0, 5'd0, 5'd0, 1'b1), 1, 0);
        step(1, I_LD,    ex(64'h328, c_ld,    5'd1, 5'd0, 5'd0, 1'b0), 1, 0);
        step(1, I_MUL,   ex(64'h32C, c_mul,   5'd0, mul_ill ? 5'd0 : 5'd1,
                            mul_ill ? 5'd0 : 5'd2, mul_ill), 1, 0);
        drain(6);

        // Flush in TWO with a competing input, then flush in ONE discarding an accept
        step(1, I_ADD, ex(64'h400, c_add, 5'd3, 5'd1, 5'd2, 1'b0), 0, 0);
        step(1, I_SUB, ex(64'h404, c_sub, 5'd3, 5'd1, 5'd2, 1'b0), 0, 0);
        step(1, I_LUI, ex(64'h408, c_lui, 5'd5, 5'd0, 5'd0, 1'b0), 0, 1);
        chk("flush2_out_valid", 64'(bus64.out_valid), 64'd0);
        chk("flush2_in_ready",  64'(bus64.in_ready), 64'd1);
        step(1, I_ADD, ex(64'h500, c_add, 5'd3, 5'd1, 5'd2, 1'b0), 0, 0);
        step(1, I_SUB, ex(64'h504, c_sub, 5'd3, 5'd1, 5'd2, 1'b0), 0, 1);
        chk("flush1_out_valid", 64'(bus64.out_valid), 64'd0);
        drain(4);
        step(1, I_ADDI, ex(64'h600, c_addi, 5'd1, 5'd0, 5'd0, 1'b0), 1, 0);
        drain(4);

        // Asynchronous reset with two entries held
        step(1, I_ADD, ex(64'h700, c_add, 5'd3, 5'd1, 5'd2, 1'b0), 0, 0);
        step(1, I_SUB, ex(64'h704, c_sub, 5'd3, 5'd1, 5'd2, 1'b0), 0, 0);
        bus64.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 64'(bus64.out_valid), 64'd0);
        chk("mrst_in_ready",  64'(bus64.in_ready), 64'd1);
        chk("mrst_out_pc",    bus64.out_pc, 64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drain(4);

        // XLEN=32 instance: RV64-only encodings and bit-25 shifts are illegal
        step32(I_LD);
        chk("x32_ld_valid", 64'(bus32.out_valid), 64'd1);
        chk("x32_ld_ill",   64'(bus32.out_illegal), 64'd1);
        chk("x32_ld_ctrl",  64'(bus32.out_ctrl), 64'd0);
        chk("x32_ld_rd",    64'(bus32.out_rd), 64'd0);
        step32(I_SRAI);
        chk("x32_srai_ill", 64'(bus32.out_illegal), 64'd1);
        step32(I_ADDW);
        chk("x32_addw_ill", 64'(bus32.out_illegal), 64'd1);
        step32(I_ADDI);
        chk("x32_addi_ill",  64'(bus32.out_illegal), 64'd0);
        chk("x32_addi_ctrl", 64'(bus32.out_ctrl), 64'(c_addi));
        chk("x32_addi_rd",   64'(bus32.out_rd), 64'd1);
        chk("x32_addi_pc",   64'(bus32.out_pc), 64'h40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
